// File: rtl/mem_read_sequencer.sv
// mem_read_sequencer: credit-based read-burst sequencer with latency-tracked skid FIFO; `MEM_RD_SEQ_STATS_EN adds stall_cnt
module mem_read_sequencer #(
  parameter int DATAW      = 8,
  parameter int DEPTH      = 512,
  parameter int ADDRW      = $clog2(DEPTH),
  parameter int LENW       = ADDRW + 1,
  parameter int RD_LATENCY = 2,
  parameter int BUF_DEPTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ADDRW-1:0] cmd_base,
  input  logic [LENW-1:0]  cmd_len,
  input  logic [ADDRW-1:0] cmd_stride,
  output logic [ADDRW-1:0] mem_raddr,
  input  logic [DATAW-1:0] mem_rdata,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [DATAW-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done
`ifdef MEM_RD_SEQ_STATS_EN
  ,output logic [31:0]     stall_cnt
`endif
);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int PW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
  localparam logic [PW-1:0] PTR_MAX = PW'(BUF_DEPTH - 1);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state_q, state_d;
  logic [ADDRW-1:0] addr_q, addr_d, stride_q, stride_d;
  logic [LENW-1:0] rem_q, rem_d;
  logic [CW-1:0] credits_q, credits_d, cnt_q, cnt_d;
  logic [RD_LATENCY-1:0] tv_q, tv_d, tl_q, tl_d;
  logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
  logic zdone_q, zdone_d;
  logic [DATAW:0] buf_q [BUF_DEPTH];
  logic accept, issue, wr, pop;
  always_comb begin
    accept    = state_q == IDLE && cmd_valid;
    issue     = state_q == ISSUE && credits_q != '0;
    wr        = tv_q[RD_LATENCY-1];
    out_valid = cnt_q != '0;
    {out_last, out_data} = buf_q[rp_q];
    pop       = out_valid && out_ready;
    cmd_ready = state_q == IDLE;
    busy      = state_q != IDLE;
    mem_raddr = addr_q;
    done      = zdone_q || (state_q == DRAIN && pop && out_last);
    state_d   = (state_q == IDLE && accept && cmd_len != '0) ? ISSUE :
                (state_q == ISSUE && issue && rem_q == LENW'(1)) ? DRAIN :
                (state_q == DRAIN && pop && out_last) ? IDLE : state_q;
    addr_d    = accept ? cmd_base : issue ? addr_q + stride_q : addr_q;
    stride_d  = accept ? cmd_stride : stride_q;
    rem_d     = accept ? cmd_len : issue ? rem_q - LENW'(1) : rem_q;
    credits_d = credits_q - CW'(issue) + CW'(pop);
    cnt_d     = cnt_q + CW'(wr) - CW'(pop);
    // tag pipeline: bit RD_LATENCY-1 lines up with mem_rdata of the matching issue
    tv_d      = RD_LATENCY'({tv_q, issue});
    tl_d      = RD_LATENCY'({tl_q, issue && rem_q == LENW'(1)});
    wp_d      = wr ? (wp_q == PTR_MAX ? '0 : wp_q + PW'(1)) : wp_q;
    rp_d      = pop ? (rp_q == PTR_MAX ? '0 : rp_q + PW'(1)) : rp_q;
    zdone_d   = accept && cmd_len == '0;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      stride_q  <= '0;
      rem_q     <= '0;
      credits_q <= CW'(BUF_DEPTH);
      cnt_q     <= '0;
      tv_q      <= '0;
      tl_q      <= '0;
      wp_q      <= '0;
      rp_q      <= '0;
      zdone_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      stride_q  <= stride_d;
      rem_q     <= rem_d;
      credits_q <= credits_d;
      cnt_q     <= cnt_d;
      tv_q      <= tv_d;
      tl_q      <= tl_d;
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      zdone_q   <= zdone_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr) buf_q[wp_q] <= {tl_q[RD_LATENCY-1], mem_rdata};
  end
`ifdef MEM_RD_SEQ_STATS_EN
  logic [31:0] stall_q, stall_d;
  always_comb begin
    stall_d   = accept ? '0 :
                (state_q == ISSUE && credits_q == '0 && !(&stall_q)) ? stall_q + 32'd1 : stall_q;
    stall_cnt = stall_q;
  end
  always_ff @(posedge clk) begin
    if (rst) stall_q <= '0;
    else stall_q <= stall_d;
  end
`endif
endmodule
